// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM states, digit limit, prescaler sizing.
// Latency: none (types and constants only).
// Backpressure: none.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Bits needed to count 0..div-1; never narrower than one bit so a
    // divide-by-one build still has a legal register.
    function automatic int presc_width(input int div);
        if (div <= 2) begin
            return 1;
        end
        return $clog2(div);
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit that counts down 9..0 and wraps 0 -> 9, raising borrow_out on the wrap.
// Latency: q updates one clock after load/en; borrow_out is combinational from en and q.
// Backpressure: none; load takes priority over en.
module bcd_digit_down
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       borrow_out
);

    // Digit register: load wins, otherwise step down with wrap to 9.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 4'd0;
        end else if (load) begin
            q <= d;
        end else if (en) begin
            q <= (q == 4'd0) ? BCD_MAX : (q - 4'd1);
        end
    end

    // Borrow into the next digit happens only on the step that wraps this one.
    assign borrow_out = en && (q == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer (99..00) with load, start, pause and a done pulse at 00.
// Latency: all outputs registered; load/start/pause take effect on the next rising edge.
// Backpressure: none; inputs are sampled every clock with priority load > pause > start.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       zero,
    output logic       done,
    output logic       load_err
);

    localparam int            PW         = presc_width(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          running_q;
    logic          zero_q;
    logic          zero_d;
    logic          done_q;
    logic          done_d;
    logic          load_err_q;
    logic          load_err_d;

    logic          load_ok;
    logic          dig_load;
    logic          dec;
    logic          last_step;
    logic          ones_borrow;
    logic          tens_borrow;
    logic [3:0]    tens_q;
    logic [3:0]    ones_q;

    // A load is only legal if both nibbles are real BCD digits.
    assign load_ok   = (load_val[7:4] <= BCD_MAX) && (load_val[3:0] <= BCD_MAX);
    // The step that takes 01 to 00 is the terminal one.
    assign last_step = (tens_q == 4'd0) && (ones_q == 4'd1);

    bcd_digit_down u_ones (
        .clk        (clk),
        .rst        (rst),
        .en         (dec),
        .load       (dig_load),
        .d          (load_val[3:0]),
        .q          (ones_q),
        .borrow_out (ones_borrow)
    );

    // Tens only moves when the ones digit wraps 0 -> 9.
    bcd_digit_down u_tens (
        .clk        (clk),
        .rst        (rst),
        .en         (ones_borrow),
        .load       (dig_load),
        .d          (load_val[7:4]),
        .q          (tens_q),
        .borrow_out (tens_borrow)
    );

    // State, prescaler and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            running_q  <= 1'b0;
            zero_q     <= 1'b1;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            running_q  <= (state_d == RUN);
            zero_q     <= zero_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    // Next-state, prescaler and pulse decisions in input priority order.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        dig_load   = 1'b0;
        dec        = 1'b0;
        done_d     = 1'b0;
        load_err_d = 1'b0;

        if (load) begin
            // A rejected load freezes everything for this clock.
            if (load_ok) begin
                dig_load = 1'b1;
                state_d  = IDLE;
                presc_d  = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (pause && (state_q == RUN)) begin
            state_d = PAUSE;
        end else if (start && (state_q == IDLE) && !zero_q) begin
            state_d = RUN;
            presc_d = '0;
        end else if (start && (state_q == PAUSE)) begin
            // Resume keeps the partial tick so pauses do not lose time.
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                dec     = !zero_q;
                if (last_step) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // zero tracks the digits without re-decoding them after the edge.
    always_comb begin
        zero_d = zero_q;
        if (dig_load) begin
            zero_d = (load_val == 8'h00);
        end else if (dec && last_step) begin
            zero_d = 1'b1;
        end
    end

    assign tens     = tens_q;
    assign ones     = ones_q;
    assign running  = running_q;
    assign zero     = zero_q;
    assign done     = done_q;
    assign load_err = load_err_q;

    // The tens digit never wraps below 0 because dec is blocked at 00;
    // its borrow therefore has no consumer.
    logic unused_tens_borrow;
    assign unused_tens_borrow = tens_borrow;

endmodule
